mmu_accumulator: RTL and testbench

- Sits directly downstream of the 16x16 matrix multiply unit and consumes its 320-bit output (16 lanes x 20-bit signed column sums).
- Holds DEPTH rows of 16 x 32-bit signed accumulators.
- Each accepted input row either overwrites or accumulates into the addressed row through a 3-stage read-modify-write pipeline with forwarding.
- A separate registered read port lets the downstream activation/writeback logic drain results.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/acc_lane.sv | 28 ++
 rtl/mmu_accumulator.sv | 145 ++++++++++++++
 tb/tb_mmu_accumulator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU constants, accumulator saturation limits and the accumulator FSM state type.
package tpu_pkg;

  localparam int LANES = 16;
  localparam int IN_W  = 20;
  localparam int ACC_W = 32;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    DRAIN
  } acc_state_e;

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: sign-extend the input, add, detect signed overflow.
// Build with ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module acc_lane
  import tpu_pkg::*;
(
  input  logic signed [ACC_W-1:0] operand_i,
  input  logic signed [IN_W-1:0]  lane_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);

  logic signed [ACC_W-1:0] lane_ext;
  logic signed [ACC_W-1:0] raw;

  assign lane_ext = {{(ACC_W-IN_W){lane_i[IN_W-1]}}, lane_i};
  assign raw      = operand_i + lane_ext;

  // Overflow only when both addends share a sign and the result's sign differs.
  assign ovf_o = (operand_i[ACC_W-1] == lane_ext[ACC_W-1]) &&
                 (raw[ACC_W-1] != operand_i[ACC_W-1]);

`ifdef ACC_SATURATE_EN
  assign sum_o = ovf_o ? (operand_i[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/mmu_accumulator.sv
// DEPTH x LANES signed accumulator array behind the MMU: read-modify-write pipeline with
// forwarding, clear/drain FSM and a registered read port. ACC_SATURATE_EN selects saturation.
module mmu_accumulator
  import tpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_acc,
  input  logic [AW-1:0]          in_addr,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_valid,
  output logic [LANES*ACC_W-1:0] rd_data,
  input  logic                   clr_start,
  output logic                   busy,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int ROW_W = LANES * ACC_W;

  acc_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic in_ready_q, busy_q, ovf_q, rd_valid_q;
  logic [ROW_W-1:0] rd_data_q;

  logic                  s1_valid_q, s1_acc_q;
  logic [AW-1:0]         s1_addr_q;
  logic [LANES*IN_W-1:0] s1_data_q;
  logic                  s3_valid_q;
  logic [AW-1:0]         s3_addr_q;
  logic [LANES*IN_W-1:0] s3_data_q;
  logic [ROW_W-1:0]      s3_op_q;

  logic [ROW_W-1:0] s2_op, s3_sum;
  logic [LANES-1:0] lane_ovf;
  logic             accept, rd_fire;

  // NOTE: the array has no reset; CLEAR zeroes it row by row after every reset.
  logic [ROW_W-1:0] mem [DEPTH];

  assign accept  = in_valid && in_ready_q;
  assign rd_fire = rd_en && (state_q == IDLE);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    acc_lane u_lane (
      .operand_i (s3_op_q[j*ACC_W +: ACC_W]),
      .lane_i    (s3_data_q[j*IN_W +: IN_W]),
      .sum_o     (s3_sum[j*ACC_W +: ACC_W]),
      .ovf_o     (lane_ovf[j])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s2_op = '0;
    if (s1_acc_q) begin
      // The row still being committed by S3 is newer than the array copy.
      s2_op = (s3_valid_q && (s3_addr_q == s1_addr_q)) ? s3_sum : mem[s1_addr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE:  if (clr_start) state_d = DRAIN;
      DRAIN: begin
        if (!s1_valid_q && !s3_valid_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      s1_valid_q <= accept;
      s3_valid_q <= s1_valid_q;
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= mem[rd_addr];
      if (s3_valid_q && (|lane_ovf)) ovf_q <= 1'b1;
      else if (ovf_clr)              ovf_q <= 1'b0;
    end
  end

  // Datapath registers are qualified by the valids above and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_acc_q  <= in_acc;
      s1_addr_q <= in_addr;
      s1_data_q <= in_data;
    end
    if (s1_valid_q) begin
      s3_addr_q <= s1_addr_q;
      s3_data_q <= s1_data_q;
      s3_op_q   <= s2_op;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR)  mem[cnt_q]     <= '0;
    else if (s3_valid_q)   mem[s3_addr_q] <= s3_sum;
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mmu_accumulator.sv
// Scoreboard bench for mmu_accumulator: an array model predicts every read, a monitor
// checks rd_valid timing and rd_data. Honours ACC_SATURATE_EN like the design.
module tb_mmu_accumulator;
  import tpu_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int ROW_W = LANES * ACC_W;
  localparam longint LMAX = (64'sd1 <<< 31) - 64'sd1;
  localparam longint LMIN = -(64'sd1 <<< 31);

  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, in_acc = 1'b0, rd_en = 1'b0, clr_start = 1'b0, ovf_clr = 1'b0;
  logic [AW-1:0] in_addr = '0, rd_addr = '0;
  logic [LANES*IN_W-1:0] in_data = '0;
  logic in_ready, rd_valid, busy, ovf;
  logic [ROW_W-1:0] rd_data;

  mmu_accumulator #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .clr_start (clr_start),
    .busy      (busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int model [DEPTH][LANES];
  bit exp_ovf = 1'b0;
  logic [ROW_W-1:0] sb_q [$];
  logic rd_expect = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int add_lane(input int op, input int x);
    longint s;
    int r;
    s = longint'(op) + longint'(x);
    r = int'(s);
    if (s > LMAX || s < LMIN) begin
      exp_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
      r = (s > LMAX) ? int'(LMAX) : int'(LMIN);
`endif
    end
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] model_row(input int a);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*ACC_W +: ACC_W] = model[a][j];
    return r;
  endfunction

  function automatic int rand_lane();
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one row for one cycle; the model is updated at acceptance time.
  task automatic send(input int a, input bit acc, input int d[LANES], input bit clr);
    in_valid  = 1'b1;
    in_acc    = acc;
    in_addr   = AW'(a);
    clr_start = clr;
    for (int j = 0; j < LANES; j++) in_data[j*IN_W +: IN_W] = IN_W'(d[j]);
    check("in_ready_at_send", int'(in_ready), 1);
    for (int j = 0; j < LANES; j++)
      model[a][j] = add_lane(acc ? model[a][j] : 0, d[j]);
    @(negedge clk);
    in_valid  = 1'b0;
    in_acc    = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic do_read(input int a, input logic [ROW_W-1:0] exp, input bit expect_v);
    rd_en     = 1'b1;
    rd_addr   = AW'(a);
    rd_expect = expect_v;
    if (expect_v) sb_q.push_back(exp);
    @(negedge clk);
    rd_en     = 1'b0;
    rd_expect = 1'b0;
  endtask

  // Monitor: a read sampled at this edge must produce rd_valid exactly one cycle later.
  always @(posedge clk) begin
    logic exp_v;
    logic [ROW_W-1:0] exp_row;
    exp_v = rd_expect;
    #1;
    if (exp_v || rd_valid === 1'b1) begin
      n_cmp++;
      if (rd_valid !== exp_v) begin
        n_err++;
        $display("FAIL rd_valid: got %b expected %b", rd_valid, exp_v);
        if (exp_v && sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_scoreboard: got rd_valid with no expected row queued");
      end else begin
        exp_row = sb_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_row) begin
          n_err++;
          $display("FAIL rd_data: got %h expected %h", rd_data, exp_row);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int d [LANES];
    int n;
    logic [ROW_W-1:0] exp_r, row_before;

    for (int a = 0; a < DEPTH; a++)
      for (int j = 0; j < LANES; j++) model[a][j] = 0;

    // Reset values, then the clear must take exactly DEPTH cycles.
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_rd_data_zero", int'(rd_data == '0), 1);
    reset_n = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", n, DEPTH);
    check("busy_after_clear", int'(busy), 0);
    do_read(5, '0, 1'b1);

    // Overwrite then immediately accumulate the same row: needs forwarding.
    for (int j = 0; j < LANES; j++) d[j] = rand_lane();
    d[0] = 100;
    send(3, 1'b0, d, 1'b0);
    for (int j = 0; j < LANES; j++) d[j] = rand_lane();
    d[0] = -30;
    send(3, 1'b1, d, 1'b0);
    idle(3);
    check("row3_lane0_model", model[3][0], 70);
    do_read(3, model_row(3), 1'b1);

    // Most negative input sign-extends.
    for (int j = 0; j < LANES; j++) d[j] = 0;
    d[7] = -524288;
    send(9, 1'b0, d, 1'b0);
    idle(3);
    exp_r = '0;
    exp_r[7*ACC_W +: ACC_W] = 32'hFFF80000;
    do_read(9, exp_r, 1'b1);

    // Read in the cycle S3 commits to the same row returns the pre-write value.
    for (int j = 0; j < LANES; j++) d[j] = 0;
    d[0] = 10;
    send(4, 1'b0, d, 1'b0);
    idle(3);
    row_before = model_row(4);
    d[0] = 1;
    send(4, 1'b1, d, 1'b0);
    idle(1);
    do_read(4, row_before, 1'b1);
    do_read(4, model_row(4), 1'b1);

    // Randomised traffic on a few rows so forwarding and gaps are exercised.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < LANES; j++) d[j] = rand_lane();
      send(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), d, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    for (int a = 0; a < 8; a++) do_read(a, model_row(a), 1'b1);
    check("ovf_after_random", int'(ovf), int'(exp_ovf));

    // 4097 accumulates of the largest positive input overflow lane 15.
    for (int j = 0; j < LANES; j++) d[j] = 0;
    send(0, 1'b0, d, 1'b0);
    d[15] = 524287;
    for (int i = 0; i < 4097; i++) send(0, 1'b1, d, 1'b0);
    idle(3);
    check("ovf_set", int'(ovf), 1);
    check("ovf_model", int'(ovf), int'(exp_ovf));
    exp_r = '0;
`ifdef ACC_SATURATE_EN
    exp_r[15*ACC_W +: ACC_W] = 32'h7FFFFFFF;
`else
    exp_r[15*ACC_W +: ACC_W] = 32'h8007EFFF;
`endif
    do_read(0, exp_r, 1'b1);
    idle(2);
    check("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", int'(ovf), 0);

    // Row offered together with clr_start is committed, then the whole array clears.
    for (int j = 0; j < LANES; j++) d[j] = 0;
    d[0] = 5;
    send(2, 1'b0, d, 1'b1);
    check("busy_on_clr", int'(busy), 1);
    check("in_ready_on_clr", int'(in_ready), 0);
    do_read(2, '0, 1'b0);
    n = 1;
    while (in_ready !== 1'b1 && n < 300) begin
      clr_start = (n >= 20 && n < 40);
      @(negedge clk);
      n++;
    end
    clr_start = 1'b0;
    check("drain_plus_clear_cycles", n, DEPTH + 3);
    check("busy_after_reclear", int'(busy), 0);
    for (int a = 0; a < DEPTH; a++)
      for (int j = 0; j < LANES; j++) model[a][j] = 0;
    do_read(2, model_row(2), 1'b1);
    do_read(0, model_row(0), 1'b1);
    check("ovf_after_clear", int'(ovf), 0);

    idle(3);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
